prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 66 ++++++
 tb/tb_prog_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: streams up to 32 bytes into a program store,
// holding the CPU in reset until the image is complete.
module prog_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    input  logic [4:0] im_abus,
    output logic [7:0] im_dbus,
    output logic       cpu_reset,
    output logic [5:0] load_count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] mem [32];
    logic [5:0] cnt;
    logic       accept;

    assign accept = ld_valid && (state == LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
        end else begin
            unique case (state)
                IDLE, RUN: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= 6'd0;
                        for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem[cnt[4:0]] <= ld_data;
                        cnt           <= cnt + 6'd1;
                        // 32nd byte closes the load even without ld_last
                        if (ld_last || cnt == 6'd31) state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ld_ready   = (state == LOAD);
    assign busy       = (state == LOAD);
    assign done       = (state == RUN);
    assign cpu_reset  = (state != RUN);
    assign load_count = cnt;
    assign im_dbus    = (state == RUN) ? mem[im_abus] : 8'h00;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: reset, short/full loads,
// gaps, reload and asynchronous reset mid-load.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic [4:0] im_abus;
    logic [7:0] im_dbus;
    logic       cpu_reset;
    logic [5:0] load_count;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .im_abus    (im_abus),
        .im_dbus    (im_dbus),
        .cpu_reset  (cpu_reset),
        .load_count (load_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = 8'h00;
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [7:0] exp);
        im_abus = a;
        #1;
        check(tag, im_dbus, exp);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;
        im_abus  = 5'd0;
        #1;
        check("rst_cpu_reset", 8'(cpu_reset), 8'd1);
        check("rst_ld_ready", 8'(ld_ready), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_count", 8'(load_count), 8'd0);
        check("rst_dbus", im_dbus, 8'h00);

        step();
        reset = 1'b0;
        step();
        step();
        check("idle_hold", 8'(busy), 8'd0);

        // short load
        do_start();
        check("load_ready", 8'(ld_ready), 8'd1);
        check("load_busy", 8'(busy), 8'd1);
        check("load_cpu_reset", 8'(cpu_reset), 8'd1);
        check("load_dbus", im_dbus, 8'h00);
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b0);
        check("short_mid_count", 8'(load_count), 8'd2);
        send(8'hC3, 1'b1);
        check("short_done", 8'(done), 8'd1);
        check("short_cpu_reset", 8'(cpu_reset), 8'd0);
        check("short_count", 8'(load_count), 8'd3);
        check("short_ready", 8'(ld_ready), 8'd0);
        rd("short_w0", 5'd0, 8'hA1);
        rd("short_w1", 5'd1, 8'hB2);
        rd("short_w2", 5'd2, 8'hC3);
        rd("short_w3", 5'd3, 8'h00);

        // reload with start/ld_valid coincidence in RUN
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        step();
        start    = 1'b0;
        ld_valid = 1'b0;
        check("reload_cpu_reset", 8'(cpu_reset), 8'd1);
        check("reload_count", 8'(load_count), 8'd0);
        check("reload_busy", 8'(busy), 8'd1);
        send(8'h5A, 1'b1);
        rd("reload_w0", 5'd0, 8'h5A);
        rd("reload_w1", 5'd1, 8'h00);
        rd("reload_w2", 5'd2, 8'h00);
        check("reload_count1", 8'(load_count), 8'd1);

        // full 32-byte load, no ld_last
        do_start();
        for (int i = 0; i < 31; i++) send(8'(i), 1'b0);
        check("full_31_ready", 8'(ld_ready), 8'd1);
        check("full_31_done", 8'(done), 8'd0);
        check("full_31_count", 8'(load_count), 8'd31);
        send(8'h1F, 1'b0);
        check("full_done", 8'(done), 8'd1);
        check("full_count", 8'(load_count), 8'd32);
        check("full_ready", 8'(ld_ready), 8'd0);
        rd("full_w31", 5'd31, 8'h1F);
        rd("full_w0", 5'd0, 8'h00);
        rd("full_w17", 5'd17, 8'h11);
        send(8'hFF, 1'b1);
        send(8'hFF, 1'b0);
        check("full_hold_count", 8'(load_count), 8'd32);
        rd("full_hold_w0", 5'd0, 8'h00);

        // gaps, ignored ld_last and start mid-load
        do_start();
        send(8'h10, 1'b0);
        ld_last = 1'b1;
        step();
        ld_last = 1'b0;
        check("gap_last_ignored", 8'(busy), 8'd1);
        check("gap_count1", 8'(load_count), 8'd1);
        do_start();
        check("gap_start_count", 8'(load_count), 8'd1);
        check("gap_start_busy", 8'(busy), 8'd1);
        send(8'h20, 1'b0);
        step();
        send(8'h30, 1'b1);
        check("gap_count", 8'(load_count), 8'd3);
        check("gap_done", 8'(done), 8'd1);
        rd("gap_w0", 5'd0, 8'h10);
        rd("gap_w1", 5'd1, 8'h20);
        rd("gap_w2", 5'd2, 8'h30);
        rd("gap_w3", 5'd3, 8'h00);

        // zero-byte load stays in LOAD
        do_start();
        for (int i = 0; i < 5; i++) step();
        check("zero_busy", 8'(busy), 8'd1);
        check("zero_done", 8'(done), 8'd0);
        check("zero_count", 8'(load_count), 8'd0);

        // async reset mid-load
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        check("mid_count2", 8'(load_count), 8'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 8'(busy), 8'd0);
        check("arst_ready", 8'(ld_ready), 8'd0);
        check("arst_count", 8'(load_count), 8'd0);
        check("arst_cpu_reset", 8'(cpu_reset), 8'd1);
        check("arst_done", 8'(done), 8'd0);
        check("arst_dbus", im_dbus, 8'h00);
        step();
        reset = 1'b0;
        step();
        check("arst_idle", 8'(busy), 8'd0);
        do_start();
        send(8'h99, 1'b1);
        check("arst_count1", 8'(load_count), 8'd1);
        rd("arst_w0", 5'd0, 8'h99);
        rd("arst_w1", 5'd1, 8'h00);
        rd("arst_w2", 5'd2, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
